// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory-port arbiter slice:
//     arb_state_e  - arbiter FSM state encoding (IDLE / ACCESS / RESP)
//     SEL_IF       - mux select / grant value for the instruction-fetch side
//     SEL_DM       - mux select / grant value for the data-memory side
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection between the fetch and data requesters.
//   On a tie the side that was NOT granted last wins; when the caller ties
//   last_grant to SEL_IF this degenerates into fixed data-side priority.
// Ports:
//   if_req     in   fetch request
//   dm_req     in   data request
//   last_grant in   side granted most recently (SEL_IF / SEL_DM)
//   winner     out  selected side; meaningful only when a request is present
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = SEL_DM;
        if (if_req && dm_req) begin
            winner = (last_grant == SEL_DM) ? SEL_IF : SEL_DM;
        end else if (if_req) begin
            winner = SEL_IF;
        end else begin
            winner = SEL_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one registered memory port between an instruction-fetch requester
//   and a data-memory requester. Each transaction is IDLE (grant) -> ACCESS
//   (MEM_LAT cycles, port held stable) -> RESP (one-cycle done pulse) -> IDLE.
//
//   Handshake: a requester raises req with its address/data stable and keeps
//   it high until it sees its one-cycle done pulse. The request is sampled
//   only in IDLE; once granted, the transaction runs to completion even if
//   req drops. rdata is valid in the done cycle (unchanged for stores).
//
//   Configuration macro MEM_ARB_RR_EN:
//     defined   - round-robin on ties via a last_grant register (resets to
//                 fetch, so the data side wins the first tie)
//     undefined - fixed priority, data side wins ties
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_req, if_addr, if_done    fetch request / address / completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_done           data request / store flag / address / store
//                               data / completion pulse
//   rdata                       read data for the completing requester
//   mem_sel                     address-mux select (0 fetch, 1 data)
//   mem_addr, mem_we, mem_wdata registered memory port
//   mem_rdata                   memory read data, valid in last ACCESS cycle
//   busy                        high whenever the FSM is not IDLE
//   dbg_state                   current FSM state (arb_state_e encoding)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2      // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Counter holds the remaining ACCESS cycles after the current one.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    arb_state_e state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       winner;
    logic       grant;

    assign grant = (state == ST_IDLE) && (if_req || dm_req);

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SEL_IF;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`else
    // Pinning last_grant to fetch makes the picker favour the data side.
    assign last_grant = SEL_IF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_sel   <= SEL_IF;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    if (grant) begin
                        mem_sel <= winner;
                        if (winner == SEL_DM) begin
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_we;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                        end
                        cnt   <= CNT_INIT;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Stores leave the last read value in place.
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        mem_we  <= 1'b0;
                        if_done <= (mem_sel == SEL_IF);
                        dm_done <= (mem_sel == SEL_DM);
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. dut0 runs with MEM_LAT=2, dut1 with
//   MEM_LAT=1. Drivers push the expected {done cycle, side, rdata} into a
//   queue; monitors pop and compare on every done pulse.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int EW  = 49;   // {cycle[15:0], side, rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut0 (MEM_LAT=2) ----------------
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_done, dm_done, mem_sel, mem_we, busy;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done),
        .rdata(rdata), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- dut1 (MEM_LAT=1) ----------------
    logic          if_req1, dm_req1, dm_we1;
    logic [AW-1:0] if_addr1, dm_addr1;
    logic [DW-1:0] dm_wdata1;
    logic          if_done1, dm_done1, mem_sel1, mem_we1, busy1;
    logic [DW-1:0] rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;
    logic [1:0]    dbg_state1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1),
        .dm_wdata(dm_wdata1), .dm_done(dm_done1),
        .rdata(rdata1), .mem_sel(mem_sel1), .mem_addr(mem_addr1),
        .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .busy(busy1), .dbg_state(dbg_state1)
    );

    // ---------------- memory models ----------------
    // Data is only valid in the last ACCESS cycle; otherwise a poison value.
    int acc0 = 0;
    int acc1 = 0;
    always @(posedge clk) acc0 <= (dbg_state == ST_ACCESS) ? acc0 + 1 : 0;
    always @(posedge clk) acc1 <= (dbg_state1 == ST_ACCESS) ? acc1 + 1 : 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    assign mem_rdata  = (dbg_state == ST_ACCESS && acc0 == LAT - 1) ?
                        mem_word(mem_addr) : 32'hBAD0BAD0;
    assign mem_rdata1 = (dbg_state1 == ST_ACCESS && acc1 == 0) ?
                        mem_word(mem_addr1) : 32'hBAD0BAD0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] e0, e1;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    endfunction

    function automatic void fail_event(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endfunction

    task automatic expect_done(input int at, input logic side, input logic [DW-1:0] d);
        exp_q.push_back({at[15:0], side, d});
    endtask

    always @(negedge clk) begin
        if (rst_n && (if_done || dm_done)) begin
            check("done_onehot", 64'(if_done & dm_done), 64'd0);
            if (exp_q.size() == 0) begin
                fail_event("unexpected_done",
                           $sformatf("got if_done=%0b dm_done=%0b, want none", if_done, dm_done));
            end else begin
                e0 = exp_q.pop_front();
                check("done_cycle", 64'(cyc[15:0]), 64'(e0[48:33]));
                check("done_side", 64'(dm_done), 64'(e0[32]));
                check("done_rdata", 64'(rdata), 64'(e0[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (if_done1 || dm_done1)) begin
            if (exp1_q.size() == 0) begin
                fail_event("lat1_unexpected_done",
                           $sformatf("got if_done=%0b dm_done=%0b, want none", if_done1, dm_done1));
            end else begin
                e1 = exp1_q.pop_front();
                check("lat1_done_cycle", 64'(cyc[15:0]), 64'(e1[48:33]));
                check("lat1_done_side", 64'(dm_done1), 64'(e1[32]));
                check("lat1_done_rdata", 64'(rdata1), 64'(e1[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_txn(input logic side, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                              input bit drop_early);
        int  n;
        int  we_cnt;
        bit  seen;
        n      = cyc;
        we_cnt = 0;
        seen   = 0;
        expect_done(n + LAT + 1, side, exp_rd);
        if (side == SEL_DM) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_we) we_cnt++;
            if (cyc == n + 1) begin
                check("grant_sel", 64'(mem_sel), 64'(side));
                check("grant_addr", 64'(mem_addr), 64'(addr));
                check("grant_busy", 64'(busy), 64'd1);
                if (we) check("grant_wdata", 64'(mem_wdata), 64'(wdata));
            end
            if (drop_early) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (if_done || dm_done) seen = 1;
        end
        if (!seen) begin
            fail_event("txn_timeout", "no done pulse within 20 cycles");
        end else begin
            check("we_cycles", 64'(we_cnt), we ? 64'(LAT) : 64'd0);
            check("resp_we_low", 64'(mem_we), 64'd0);
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        tick();
        check("idle_gap", 64'(busy), 64'd0);
    endtask

    task automatic both_four();
        int n;
        int dones;
        n     = cyc;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 0) expect_done(n + 3 + 4 * k, SEL_DM, 32'hC0DE0400);
            else            expect_done(n + 3 + 4 * k, SEL_IF, 32'hC0DE0300);
`else
            expect_done(n + 3 + 4 * k, SEL_DM, 32'hC0DE0400);
`endif
        end
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        for (int i = 0; i < 40 && dones < 4; i++) begin
            tick();
            if (if_done || dm_done) dones++;
        end
        if (dones < 4) fail_event("tie_timeout", $sformatf("got %0d dones, want 4", dones));
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        check("tie_idle", 64'(busy), 64'd0);
    endtask

    task automatic reset_abort();
        int  m;
        bit  seen;
        seen = 0;
        if_req = 1'b1; if_addr = 32'h40;
        tick();                              // 1st ACCESS cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        tick();                              // 2nd ACCESS cycle
        check("pre_reset_state", 64'(dbg_state), 64'(ST_ACCESS));
        rst_n = 1'b0;
        #1;
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_if_done", 64'(if_done), 64'd0);
        check("rst_dm_done", 64'(dm_done), 64'd0);
        check("rst_mem_sel", 64'(mem_sel), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        if_req = 1'b0;
        tick();
        tick();
        check("rst_hold_if_done", 64'(if_done), 64'd0);
        rst_n = 1'b1;
        m = cyc;
        expect_done(m + LAT + 1, SEL_DM, 32'hC0DE0500);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (if_done || dm_done) seen = 1;
        end
        if (!seen) fail_event("post_reset_timeout", "pending dm_req never completed");
        dm_req = 1'b0;
        tick();
    endtask

    task automatic lat1_stream();
        int n;
        int dones;
        int idle_cnt;
        n        = cyc;
        dones    = 0;
        idle_cnt = 0;
        for (int k = 0; k < 3; k++) exp1_q.push_back({16'(n + 2 + 3 * k), SEL_DM, 32'hC0DE0600});
        dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h600;
        for (int i = 0; i < 30 && dones < 3; i++) begin
            tick();
            if (dones >= 1 && !busy1) idle_cnt++;
            if (dm_done1) dones++;
        end
        if (dones < 3) fail_event("lat1_timeout", $sformatf("got %0d dones, want 3", dones));
        check("lat1_idle_cycles", 64'(idle_cnt), 64'd2);
        dm_req1 = 1'b0;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = '0; dm_wdata1 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", 64'(busy), 64'd0);
        check("init_done", 64'({if_done, dm_done}), 64'd0);
        check("init_mem_we", 64'(mem_we), 64'd0);
        check("init_rdata", 64'(rdata), 64'd0);
        check("init_lat1_busy", 64'(busy1), 64'd0);
        rst_n = 1'b1;
        tick();

        single_txn(SEL_IF, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0);
        single_txn(SEL_DM, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b0);
        single_txn(SEL_DM, 1'b0, 32'h200, 32'h0,        32'hC0DE0200, 1'b0);
        single_txn(SEL_IF, 1'b0, 32'h240, 32'h0,        32'hC0DE0240, 1'b1);
        both_four();
        reset_abort();
        lat1_stream();

        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp1_q.size() != 0); i++) tick();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp1_q_drained", 64'(exp1_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, 32, data width of read/write paths.
REQ-003 Parameter MEM_LAT, 2, memory access cycles per transaction, legal range 1..15.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch request; held until if_done.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_done  output  1  one-cycle completion pulse to fetch.
REQ-009 dm_req  input  1  data-memory request; held until dm_done.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_addr  input  ADDR_W  load/store address.
REQ-012 dm_wdata  input  DATA_W  store data.
REQ-013 dm_done  output  1  one-cycle completion pulse to data side.
REQ-014 rdata  output  DATA_W  read data, valid in the cycle of either done pulse.
REQ-015 mem_sel  output  1  address-mux select: 0 = fetch, 1 = data.
REQ-016 mem_addr, mem_we, mem_wdata  output  ADDR_W/1/DATA_W  registered single memory port.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid in the last ACCESS cycle.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-020 IDLE: if any request is present, pick a winner, latch its addr/we/wdata into the mem_* registers, set mem_sel, load the counter with MEM_LAT-1, go to ACCESS; with no request, stay in IDLE.
REQ-021 ACCESS: hold mem_* stable; decrement the counter; at count 0 capture mem_rdata into rdata and go to RESP.
REQ-022 RESP: pulse exactly one of if_done/dm_done, selected by mem_sel, drive mem_we low, go to IDLE.
REQ-023 Latency: request sampled in IDLE at cycle N -> done asserted in cycle N+MEM_LAT+1.
REQ-024 One mandatory IDLE cycle between transactions; maximum throughput is one transaction per MEM_LAT+2 cycles.
REQ-025 Loads and fetches leave mem_we 0; for stores, mem_we is 1 for all ACCESS cycles and rdata is unchanged.
REQ-026 Simultaneous requests without the macro: data side wins (fixed priority).
REQ-027 A request dropped mid-transaction SHALL NOT abort it; the done pulse is still issued.
REQ-028 MEM_LAT=1: ACCESS lasts exactly one cycle.
REQ-029 A requester's done SHALL never assert while its req was low at grant time.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, with mem_sel, mem_we, if_done, dm_done and busy at 0, and mem_addr, mem_wdata and rdata at all-zeros.
REQ-031 Reset during ACCESS SHALL abandon the transaction with no done pulse; after release, arbitration restarts from the reset priority state.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: round-robin arbitration; a last_grant register (reset 0 = fetch) selects, on simultaneous requests, the side not granted last, so the data side wins the first tie after reset.
REQ-033 With MEM_ARB_RR_EN defined, no requester SHALL wait more than one foreign transaction.
REQ-034 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-026 and no last_grant register.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and the constants SEL_IF=0 and SEL_DM=1.
REQ-036 Winner selection SHALL be a sub-module mem_arb_pick (inputs: both reqs and last_grant; output: winner).

Verification
REQ-037 if_req=1, if_addr=0x40, MEM_LAT=2, mem_rdata=0xDEADBEEF -> mem_sel=0, if_done at N+3, rdata=0xDEADBEEF.
REQ-038 dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 -> mem_we=1 for 2 cycles, dm_done at N+3, rdata unchanged.
REQ-039 Both requesters held high for 4 transactions: fixed priority gives DM,DM,DM,DM; MEM_ARB_RR_EN gives DM,IF,DM,IF.
REQ-040 rst_n low in the 2nd ACCESS cycle of a fetch -> no if_done, all outputs 0; after release a pending dm_req completes normally.
REQ-041 MEM_LAT=1 with dm_req held -> transactions complete every 3 cycles, with exactly one IDLE cycle between them.
